// File: rtl/systolic_tile_scheduler.sv
// Tile walker for the systolic array: for every output tile (row, col) it loads and
// computes each reduction tile k, then drains the accumulated results.
module systolic_tile_scheduler #(
  parameter int M = 256,
  parameter int T = 16,
  localparam int NT = M / T,
  localparam int IW = (NT > 1) ? $clog2(NT) : 1,
  localparam int CW = $clog2(3 * T)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] tile_row,
  output logic [IW-1:0] tile_col,
  output logic [IW-1:0] tile_k,
  output logic          load_req,
  input  logic          load_ack,
  output logic          array_en,
  output logic          acc_clear,
  output logic          drain_req,
  input  logic          drain_ack,
  output logic [2*IW:0] tiles_done,
  output logic [2:0]    dbg_state
);

  // Handshakes: a req is raised from the state register and held steady until the
  // matching ack is seen high at a rising edge; that edge is the transfer. Acks are
  // don't-care whenever the corresponding req is low.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(NT - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(3 * T - 3);

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_row;
  logic [IW-1:0] r_col;
  logic [IW-1:0] r_k;
  logic [2*IW:0] r_tiles;
  logic          w_cnt_last;
  logic          w_row_last;
  logic          w_col_last;
  logic          w_k_last;

  assign w_cnt_last = (r_cnt == LAST_CNT);
  assign w_row_last = (r_row == LAST_IDX);
  assign w_col_last = (r_col == LAST_IDX);
  assign w_k_last   = (r_k == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:    if (start) w_next_state = S_LOAD;
        S_LOAD:    if (load_ack) w_next_state = S_COMPUTE;
        S_COMPUTE: if (w_cnt_last) w_next_state = w_k_last ? S_DRAIN : S_LOAD;
        S_DRAIN:   if (drain_ack) w_next_state = (w_col_last && w_row_last) ? S_DONE : S_LOAD;
        S_DONE:    w_next_state = S_IDLE;
        default:   w_next_state = S_IDLE;
      endcase
    end
  end

  // Index and counter updates; abort freezes everything so software can inspect progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_k     <= '0;
      r_tiles <= '0;
    end else if (!abort) begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row   <= '0;
            r_col   <= '0;
            r_k     <= '0;
            r_tiles <= '0;
          end
        end
        S_LOAD: r_cnt <= '0;
        S_COMPUTE: begin
          if (w_cnt_last) begin
            r_cnt <= '0;
            if (!w_k_last) r_k <= r_k + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_ack) begin
            r_tiles <= r_tiles + 1'b1;
            r_k     <= '0;
            if (!w_col_last) begin
              r_col <= r_col + 1'b1;
            end else begin
              r_col <= '0;
              if (!w_row_last) r_row <= r_row + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Moore decode of registered state keeps every output edge-aligned.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    load_req  = 1'b0;
    array_en  = 1'b0;
    acc_clear = 1'b0;
    drain_req = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        busy     = 1'b1;
        load_req = 1'b1;
      end
      S_COMPUTE: begin
        busy      = 1'b1;
        array_en  = 1'b1;
        acc_clear = (r_cnt == '0) && (r_k == '0);
      end
      S_DRAIN: begin
        busy      = 1'b1;
        drain_req = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign tile_row   = r_row;
  assign tile_col   = r_col;
  assign tile_k     = r_k;
  assign tiles_done = r_tiles;
  assign dbg_state  = r_state;

endmodule
